sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL: parameter ROW_BITS, default 4, row address width driven to the row decoder.
REQ-002 SHALL: parameter COL_BITS, default 4, column address width driven to the column decoder.
REQ-003 SHALL: parameter DATA_WIDTH, default 8, read and write data width.
REQ-004 SHALL: parameter PRE_CYCLES, default 2, precharge duration in cycles; legal range is 1..15.
REQ-005 SHALL: parameter WL_CYCLES, default 2, wordline-active duration in cycles; legal range is 1..15.
REQ-006 SHALL: clk  input  1  single clock; all state is updated on the rising edge.
REQ-007 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL: req_valid  input  1  request present.
REQ-009 SHALL: req_ready  output  1  controller can accept a request.
REQ-010 SHALL: req_we  input  1  1 = write, 0 = read.
REQ-011 SHALL: req_addr  input  ROW_BITS+COL_BITS  upper bits select the row, lower bits select the column.
REQ-012 SHALL: req_wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL: rsp_valid  output  1  one-cycle completion pulse.
REQ-014 SHALL: rsp_rdata  output  DATA_WIDTH  read data, held until the next read capture.
REQ-015 SHALL: row_addr  output  ROW_BITS  to the row decoder.
REQ-016 SHALL: col_addr  output  COL_BITS  to the column decoder.
REQ-017 SHALL: dec_en  output  1  decoder enable.
REQ-018 SHALL: precharge_en  output  1  bitline precharge, active high.
REQ-019 SHALL: wl_en  output  1  wordline drive enable.
REQ-020 SHALL: wr_drv_en  output  1  write driver enable.
REQ-021 SHALL: sae  output  1  sense amplifier enable.
REQ-022 SHALL: wdata_out  output  DATA_WIDTH  data to the write drivers.
REQ-023 SHALL: sense_data  input  DATA_WIDTH  sense amplifier outputs.

Function
REQ-024 SHALL: FSM states are IDLE, PRECHARGE, ACCESS, SENSE and DONE.
REQ-025 SHALL: every array-side output and req_ready is decoded only from registered state, with no combinational path from any input.
REQ-026 SHALL: req_ready is 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-027 SHALL: on accept, req_we, req_addr and req_wdata are captured into registers; row_addr, col_addr and wdata_out come from these registers and stay stable until the next accept.
REQ-028 SHALL: accept moves IDLE to PRECHARGE; PRECHARGE lasts PRE_CYCLES cycles with precharge_en=1 and dec_en=0, then moves to ACCESS.
REQ-029 SHALL: ACCESS lasts WL_CYCLES cycles with dec_en=1 and wl_en=1, and with wr_drv_en=1 for a write; ACCESS then moves to SENSE for a read or to DONE for a write.
REQ-030 SHALL: SENSE lasts 1 cycle with dec_en=1, wl_en=1 and sae=1; sense_data is loaded into rsp_rdata at the end of SENSE.
REQ-031 SHALL: DONE lasts 1 cycle with all enables 0 and rsp_valid=1, then moves to IDLE.
REQ-032 SHALL: precharge_en and wl_en are never 1 in the same cycle, and wr_drv_en and sae are never 1 in the same cycle.
REQ-033 SHALL: with accept at cycle T, read rsp_valid is 1 at T+PRE_CYCLES+WL_CYCLES+2 and write rsp_valid is 1 at T+PRE_CYCLES+WL_CYCLES+1.
REQ-034 SHALL: the earliest next accept is the cycle after DONE, and no request is accepted while a request is in flight.
REQ-035 SHALL: a write leaves rsp_rdata unchanged.
REQ-036 SHALL: one duration counter of width 4 is shared by PRECHARGE and ACCESS and is reloaded on every state entry.

Reset
REQ-037 SHALL: while rst_n=0, all state is asynchronously forced to IDLE, with every enable, rsp_valid, the counter and the captured registers at 0, rsp_rdata at 0, and req_ready at 1.
REQ-038 SHALL: a reset asserted mid-operation deasserts wl_en, wr_drv_en and sae immediately, with no rsp_valid pulse for the aborted request.
REQ-039 SHALL: the first accept after reset release is possible on the first rising edge where rst_n=1.

Structure
REQ-040 SHALL: the state encoding enum and the default widths and timing constants belong in a shared sram package.
REQ-041 SHALL: the timing counter is one sub-module, sram_timer, with load, value and done signals.
REQ-042 SHALL: the controller drives the existing row and column decoders and contains no decode logic.

Verification
REQ-043 SHALL: read case -- reset, then read addr 0x3A with sense_data=0xC5, defaults -> precharge_en at T+1..T+2, wl_en at T+3..T+5, sae at T+5, rsp_valid at T+6, rsp_rdata=0xC5, row_addr=3, col_addr=0xA.
REQ-044 SHALL: write case -- write addr 0xFF, wdata 0x5A -> wr_drv_en at T+3..T+4, wdata_out=0x5A, sae never 1, rsp_valid at T+5, rsp_rdata unchanged.
REQ-045 SHALL: back-to-back case -- req_valid held high for two reads -> second accept at T+7, and req_addr changes while busy are ignored.
REQ-046 SHALL: reset-mid-ACCESS case -- rst_n=0 at T+4 -> wl_en=0 within the same cycle, no rsp_valid, req_ready=1 after release.
REQ-047 SHALL: parameter case -- PRE_CYCLES=1 and WL_CYCLES=1 -> read rsp_valid at T+4, and the assertion precharge_en&wl_en=0 holds throughout.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: default geometry, timing
// constants, FSM state encoding and the duration-counter type.
package sram_controller_pkg;

  localparam int unsigned DEF_ROW_BITS   = 4;
  localparam int unsigned DEF_COL_BITS   = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRE_CYCLES = 2;
  localparam int unsigned DEF_WL_CYCLES  = 2;
  localparam int unsigned TIMER_BITS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACCESS,
    ST_SENSE,
    ST_DONE
  } sram_state_t;

  typedef logic [TIMER_BITS-1:0] timer_t;

  // A phase of n cycles counts n-1 down to 0 and leaves when the count is 0.
  function automatic timer_t cycles_to_load(input int unsigned n);
    return timer_t'(n - 1);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bus of the SRAM controller.
interface sram_controller_if
  import sram_controller_pkg::*;
#(
  parameter int unsigned ROW_BITS   = DEF_ROW_BITS,
  parameter int unsigned COL_BITS   = DEF_COL_BITS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [ROW_BITS+COL_BITS-1:0] req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic                         rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_controller_timer.sv
// Shared phase-duration counter: loads a start value, counts down to zero
// and reports done while the count is zero.
module sram_timer
  import sram_controller_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  timer_t value,
  output logic   done
);

  timer_t count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - timer_t'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// SRAM array sequencer: accepts one request at a time and steps the array
// through precharge, wordline access and (for reads) sensing.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ROW_BITS   = DEF_ROW_BITS,
  parameter int unsigned COL_BITS   = DEF_COL_BITS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int unsigned WL_CYCLES  = DEF_WL_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_controller_if.slave      bus,
  output logic [ROW_BITS-1:0]   row_addr,
  output logic [COL_BITS-1:0]   col_addr,
  output logic                  dec_en,
  output logic                  precharge_en,
  output logic                  wl_en,
  output logic                  wr_drv_en,
  output logic                  sae,
  output logic [DATA_WIDTH-1:0] wdata_out,
  input  logic [DATA_WIDTH-1:0] sense_data
);

  localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS;

  sram_state_t           state;
  sram_state_t           state_nxt;
  logic                  accept;
  logic                  we_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  timer_load;
  timer_t                timer_value;
  logic                  timer_done;

  assign accept = (state == ST_IDLE) && bus.req_valid;

  sram_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture; these registers feed the decoders and write drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Read data is sampled from the sense amps at the end of SENSE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state == ST_SENSE) begin
      rdata_q <= sense_data;
    end
  end

  // Next state and timer reload; the timer is reloaded on every state entry.
  always_comb begin
    state_nxt   = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt   = ST_PRECHARGE;
          timer_load  = 1'b1;
          timer_value = cycles_to_load(PRE_CYCLES);
        end
      end
      ST_PRECHARGE: begin
        if (timer_done) begin
          state_nxt   = ST_ACCESS;
          timer_load  = 1'b1;
          timer_value = cycles_to_load(WL_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (timer_done) begin
          state_nxt  = we_q ? ST_DONE : ST_SENSE;
          timer_load = 1'b1;
        end
      end
      ST_SENSE: begin
        state_nxt  = ST_DONE;
        timer_load = 1'b1;
      end
      ST_DONE: begin
        state_nxt  = ST_IDLE;
        timer_load = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Array-side enables decoded purely from the registered state.
  always_comb begin
    precharge_en = 1'b0;
    dec_en       = 1'b0;
    wl_en        = 1'b0;
    wr_drv_en    = 1'b0;
    sae          = 1'b0;
    case (state)
      ST_PRECHARGE: precharge_en = 1'b1;
      ST_ACCESS: begin
        dec_en    = 1'b1;
        wl_en     = 1'b1;
        wr_drv_en = we_q;
      end
      ST_SENSE: begin
        dec_en = 1'b1;
        wl_en  = 1'b1;
        sae    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_rdata = rdata_q;
  assign row_addr      = addr_q[ADDR_BITS-1:COL_BITS];
  assign col_addr      = addr_q[COL_BITS-1:0];
  assign wdata_out     = wdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a default-timing instance and a PRE=1/WL=1
// instance share one request stream; a timeline model predicts every output.
module tb_sram_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [7:0] sense_data = '0;

  logic       rdy [2];
  logic       rv [2];
  logic [7:0] rdat [2];
  logic [3:0] row_a [2];
  logic [3:0] col_a [2];
  logic       dec [2];
  logic       pre_en [2];
  logic       wl [2];
  logic       wr [2];
  logic       sa [2];
  logic [7:0] wdo [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  sram_controller_if #(.ROW_BITS(4), .COL_BITS(4), .DATA_WIDTH(8)) bus0 ();
  sram_controller_if #(.ROW_BITS(4), .COL_BITS(4), .DATA_WIDTH(8)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_valid = req_valid;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign rdy[0]  = bus0.req_ready;
  assign rdy[1]  = bus1.req_ready;
  assign rv[0]   = bus0.rsp_valid;
  assign rv[1]   = bus1.rsp_valid;
  assign rdat[0] = bus0.rsp_rdata;
  assign rdat[1] = bus1.rsp_rdata;

  sram_controller #(.ROW_BITS(4), .COL_BITS(4), .DATA_WIDTH(8),
                    .PRE_CYCLES(2), .WL_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .row_addr(row_a[0]), .col_addr(col_a[0]), .dec_en(dec[0]),
    .precharge_en(pre_en[0]), .wl_en(wl[0]), .wr_drv_en(wr[0]), .sae(sa[0]),
    .wdata_out(wdo[0]), .sense_data(sense_data)
  );

  sram_controller #(.ROW_BITS(4), .COL_BITS(4), .DATA_WIDTH(8),
                    .PRE_CYCLES(1), .WL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .row_addr(row_a[1]), .col_addr(col_a[1]), .dec_en(dec[1]),
    .precharge_en(pre_en[1]), .wl_en(wl[1]), .wr_drv_en(wr[1]), .sae(sa[1]),
    .wdata_out(wdo[1]), .sense_data(sense_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, the cycle of acceptance and the captured
  // request; every output follows from the offset since acceptance.
  int          pre_c [2] = '{2, 1};
  int          wl_c  [2] = '{2, 1};
  int          cyc = 0;
  int          t_acc [2] = '{0, 0};
  logic        busy [2] = '{1'b0, 1'b0};
  logic        we_m [2] = '{1'b0, 1'b0};
  logic [7:0]  addr_m [2] = '{8'h0, 8'h0};
  logic [7:0]  wd_m [2] = '{8'h0, 8'h0};
  logic [7:0]  rdata_m [2] = '{8'h0, 8'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        busy[d] = 1'b0; we_m[d] = 1'b0; addr_m[d] = '0;
        wd_m[d] = '0;   rdata_m[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic int k = cyc - t_acc[d];
        automatic int last = pre_c[d] + wl_c[d] + (we_m[d] ? 1 : 2);
        if (busy[d]) begin
          if (!we_m[d] && k == pre_c[d] + wl_c[d] + 1) rdata_m[d] = sense_data;
          if (k == last) busy[d] = 1'b0;
        end else if (req_valid) begin
          busy[d] = 1'b1; t_acc[d] = cyc; we_m[d] = req_we;
          addr_m[d] = req_addr; wd_m[d] = req_wdata;
        end
      end
      cyc++;
    end
  end

  // Every falling edge: compare both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int   k = cyc - t_acc[d];
      automatic int   pw = pre_c[d] + wl_c[d];
      automatic logic p = busy[d] && k <= pre_c[d];
      automatic logic a = busy[d] && k > pre_c[d] && k <= pw;
      automatic logic s = busy[d] && !we_m[d] && k == pw + 1;
      automatic logic dn = busy[d] && k == pw + (we_m[d] ? 1 : 2);
      automatic logic [6:0] exp_ctl = {!busy[d], p, a | s, a | s, a & we_m[d], s, dn};
      automatic logic [6:0] got_ctl = {rdy[d], pre_en[d], dec[d], wl[d], wr[d], sa[d], rv[d]};
      check($sformatf("d%0d ctl", d), 32'(got_ctl), 32'(exp_ctl));
      check($sformatf("d%0d addr", d), 32'({row_a[d], col_a[d]}), 32'(addr_m[d]));
      check($sformatf("d%0d wdata_out", d), 32'(wdo[d]), 32'(wd_m[d]));
      check($sformatf("d%0d rsp_rdata", d), 32'(rdat[d]), 32'(rdata_m[d]));
      check($sformatf("d%0d exclusive", d),
            32'({pre_en[d] & wl[d], wr[d] & sa[d]}), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a request and wait (bounded) until the default instance takes it.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] wd,
                      output int unsigned waited);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    waited = 0;
    while (!rdy[0] && waited < 40) begin
      step();
      waited++;
    end
    check("accept timeout", 32'(rdy[0]), 32'd1);
    step();
  endtask

  initial begin
    int unsigned w;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset ready", 32'(rdy[0]), 32'd1);
    check("reset rdata", 32'(rdat[0]), 32'd0);
    rst_n = 1'b1;

    // Read 0x3A, sense 0xC5.
    sense_data = 8'hC5;
    send(1'b0, 8'h3A, 8'h00, w);
    req_valid = 1'b0;
    check("rd pre T+1", 32'(pre_en[0]), 32'd1);
    step(); step();
    check("rd wl T+3", 32'(wl[0]), 32'd1);
    step();
    check("fast rd valid T+4", 32'(rv[1]), 32'd1);
    step();
    check("rd sae T+5", 32'(sa[0]), 32'd1);
    step();
    check("rd valid T+6", 32'(rv[0]), 32'd1);
    check("rd rdata", 32'(rdat[0]), 32'hC5);
    check("rd row", 32'(row_a[0]), 32'h3);
    check("rd col", 32'(col_a[0]), 32'hA);
    repeat (2) step();

    // Write 0xFF <- 0x5A.
    sense_data = 8'h11;
    send(1'b1, 8'hFF, 8'h5A, w);
    req_valid = 1'b0;
    step(); step();
    check("wr drv T+3", 32'(wr[0]), 32'd1);
    check("wr wdata_out", 32'(wdo[0]), 32'h5A);
    step(); step();
    check("wr valid T+5", 32'(rv[0]), 32'd1);
    check("wr rdata kept", 32'(rdat[0]), 32'hC5);
    repeat (3) step();

    // Back-to-back reads with valid held; address change while busy.
    send(1'b0, 8'h12, 8'h00, w);
    req_addr = 8'h34;
    send(1'b0, 8'h34, 8'h00, w);
    check("b2b second accept gap", 32'(w), 32'd6);
    req_valid = 1'b0;
    repeat (12) step();

    // Reset during ACCESS.
    send(1'b0, 8'h55, 8'h00, w);
    req_valid = 1'b0;
    repeat (3) step();
    check("pre-reset wl", 32'(wl[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset wl drop", 32'(wl[0]), 32'd0);
    check("reset rsp_valid", 32'(rv[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ready after release", 32'(rdy[0]), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      req_valid  = ($urandom_range(0, 99) < 60);
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = 8'($urandom);
      req_wdata  = 8'($urandom);
      sense_data = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    req_valid = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
